// File: rtl/rtc_bcd_timekeeper.sv
// rtc_bcd_timekeeper: 24-hour BCD HH:MM:SS clock with 1 s prescaler and two-button hour/minute set mode.
module rtc_bcd_timekeeper #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [3:0] hr_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       set_hr,
  output logic       set_min,
  output logic       sec_pulse
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TMAX = PW'(TICK_DIV - 1);
  typedef enum logic [1:0] {RUN, SET_HR, SET_MIN} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0] hr_tens_q, hr_tens_d, hr_ones_q, hr_ones_d;
  logic [3:0] min_tens_q, min_tens_d, min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d, sec_ones_q, sec_ones_d;
  logic sec_pulse_q, sec_pulse_d;
  logic run, tick, clr_sec, sec_carry, min_inc, min_carry, hr_inc, hr_wrap, adj;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      presc_q     <= '0;
      hr_tens_q   <= '0;
      hr_ones_q   <= '0;
      min_tens_q  <= '0;
      min_ones_q  <= '0;
      sec_tens_q  <= '0;
      sec_ones_q  <= '0;
      sec_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      hr_tens_q   <= hr_tens_d;
      hr_ones_q   <= hr_ones_d;
      min_tens_q  <= min_tens_d;
      min_ones_q  <= min_ones_d;
      sec_tens_q  <= sec_tens_d;
      sec_ones_q  <= sec_ones_d;
      sec_pulse_q <= sec_pulse_d;
    end
  end
  always_comb begin
    state_d = !mode_btn ? state_q :
              state_q == RUN ? SET_HR :
              state_q == SET_HR ? SET_MIN : RUN;
  end
  always_comb begin
    run         = state_q == RUN;
    tick        = run && presc_q == TMAX;
    adj         = inc_btn && !mode_btn;
    clr_sec     = state_q == SET_MIN && mode_btn;
    presc_d     = (!run || tick) ? '0 : presc_q + PW'(1);
    sec_pulse_d = tick;
    sec_ones_d  = clr_sec ? 4'd0 : tick ? (sec_ones_q == 4'd9 ? 4'd0 : sec_ones_q + 4'd1) : sec_ones_q;
    sec_tens_d  = clr_sec ? 4'd0 : (tick && sec_ones_q == 4'd9) ?
                  (sec_tens_q == 4'd5 ? 4'd0 : sec_tens_q + 4'd1) : sec_tens_q;
    sec_carry   = tick && sec_ones_q == 4'd9 && sec_tens_q == 4'd5;
    min_inc     = sec_carry || (state_q == SET_MIN && adj);
    min_ones_d  = min_inc ? (min_ones_q == 4'd9 ? 4'd0 : min_ones_q + 4'd1) : min_ones_q;
    min_tens_d  = (min_inc && min_ones_q == 4'd9) ?
                  (min_tens_q == 4'd5 ? 4'd0 : min_tens_q + 4'd1) : min_tens_q;
    min_carry   = sec_carry && min_ones_q == 4'd9 && min_tens_q == 4'd5;
    hr_inc      = min_carry || (state_q == SET_HR && adj);
    hr_wrap     = hr_tens_q == 4'd2 && hr_ones_q == 4'd3;
    hr_ones_d   = hr_inc ? ((hr_wrap || hr_ones_q == 4'd9) ? 4'd0 : hr_ones_q + 4'd1) : hr_ones_q;
    hr_tens_d   = !hr_inc ? hr_tens_q : hr_wrap ? 4'd0 :
                  hr_ones_q == 4'd9 ? hr_tens_q + 4'd1 : hr_tens_q;
  end
  always_comb begin
    set_hr    = state_q == SET_HR;
    set_min   = state_q == SET_MIN;
    sec_pulse = sec_pulse_q;
    hr_tens   = hr_tens_q;
    hr_ones   = hr_ones_q;
    min_tens  = min_tens_q;
    min_ones  = min_ones_q;
    sec_tens  = sec_tens_q;
    sec_ones  = sec_ones_q;
  end
endmodule

// File: doc/rtc_bcd_timekeeper.md
Name: rtc_bcd_timekeeper

Overview:
- 24-hour HH:MM:SS timekeeper for the real-time clock display path.
- Divides the system clock down to a 1 s tick and keeps time as six BCD digits. Each digit drives one 4-bit seven-segment decoder instance directly downstream.
- Provides a two-button set mode that adjusts hours and minutes.

Parameters:
- TICK_DIV, 50000000: system clock cycles per second; must be >= 2. Benches use 4.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- mode_btn  input  1  single-cycle pulse (debounced upstream). Cycles the mode.
- inc_btn  input  1  single-cycle pulse (debounced upstream). Increments the selected field in set mode.
- hr_tens  output  4  BCD hours tens digit, 0-2.
- hr_ones  output  4  BCD hours ones digit, 0-9.
- min_tens  output  4  BCD minutes tens digit, 0-5.
- min_ones  output  4  BCD minutes ones digit, 0-9.
- sec_tens  output  4  BCD seconds tens digit, 0-5.
- sec_ones  output  4  BCD seconds ones digit, 0-9.
- set_hr  output  1  high while in SET_HR state.
- set_min  output  1  high while in SET_MIN state.
- sec_pulse  output  1  one-cycle strobe, coincident with each seconds update in RUN.

Behaviour:
- Reset and timing:
  - rst is synchronous, active-high, and overrides all other inputs, including mid-set.
  - After the reset edge: all digits 0 (00:00:00), state RUN, prescaler 0, sec_pulse 0, set_hr 0, set_min 0.
  - All outputs are registered. Digit changes are visible in the cycle after the edge that samples the causing event.
- State machine (set_hr/set_min decode directly from state):
  - RUN -> SET_HR on mode_btn.
  - SET_HR -> SET_MIN on mode_btn.
  - SET_MIN -> RUN on mode_btn.
  - No other transitions.
- Prescaler in RUN:
  - Counts 0..TICK_DIV-1.
  - At TICK_DIV-1 the next edge wraps it to 0, advances seconds by 1 and sets sec_pulse=1 for exactly one cycle.
  - On all other edges sec_pulse=0.
  - Result: one sec_pulse every TICK_DIV cycles, the first TICK_DIV cycles after reset release.
- Carry chain (RUN):
  - sec_ones 9->0 increments sec_tens.
  - Seconds 59->00 carries into minutes.
  - Minutes 59->00 carries into hours.
  - Hours 23->00 wraps with no further carry. 23:59:59 -> 00:00:00 on a single tick.
- Set modes (SET_HR, SET_MIN):
  - Prescaler held at 0, seconds frozen, sec_pulse held 0.
  - inc_btn in SET_HR: hours +1 mod 24 (23->00). Minutes and seconds unaffected.
  - inc_btn in SET_MIN: minutes +1 mod 60 (59->00). No carry into hours.
  - inc_btn in RUN: ignored.
- Exit from SET_MIN to RUN: seconds cleared to 00 and prescaler to 0 on the same edge. The first sec_pulse follows TICK_DIV cycles later.
- Simultaneous mode_btn and inc_btn: the mode transition is taken and inc_btn is ignored for that cycle.
- Pulse inputs held high: counted as one event per cycle. Limiting this is the upstream debouncer's responsibility.
- Digit validity: outputs never show non-BCD values or out-of-range times (e.g. 24:xx, x6x seconds) at any cycle.
- Arithmetic: per-digit 4-bit BCD increment with explicit tens/ones limit compares; no binary-to-BCD conversion.

Test Plan:
1. Assert rst for 2 cycles with mode_btn and inc_btn toggling -> all digits 0, set_hr=set_min=0, sec_pulse=0.
2. TICK_DIV=4, release reset, run 240 cycles:
   - sec_pulse high on cycles 4, 8, ... 240.
   - After the 60th pulse the digits read 00:01:00.
   - sec_ones sequence 0..9 then sec_tens increments.
3. Rollover:
   - Enter SET_HR, apply 23 inc pulses -> hr 2,3.
   - Enter SET_MIN, apply 59 inc pulses -> min 5,9.
   - Exit to RUN -> seconds 00.
   - Run 59 ticks -> 23:59:59; one more tick -> 00:00:00.
4. Set-mode freeze and wrap:
   - In SET_HR hold 100 cycles -> seconds unchanged, no sec_pulse.
   - 24 inc pulses -> hours return to the original value.
   - In SET_MIN at 59, one inc -> 00 with hours unchanged.
5. At 05:30:xx in SET_HR, pulse mode_btn and inc_btn on the same cycle -> state SET_MIN (set_min=1, set_hr=0), hours still 05, minutes still 30.
6. In SET_MIN with minutes 42, assert rst for 1 cycle -> 00:00:00, RUN, next sec_pulse exactly TICK_DIV cycles after reset release.
